// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: owns the fetch PC, applies EX-resolved redirects, generates
// IF/ID and ID/EX squash bubbles for wrong-path instructions, handles
// halt/resume, and counts taken redirects (saturating).
module fetch_pc_ctrl #(
    parameter int              PC_W         = 9,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [31:0]     br_pc,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            if_flush,
    output logic            id_flush,
    output logic            halted,
    output logic            misalign_err,
    output logic [15:0]     redirect_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_INC    = PC_W'(4);
    localparam logic [2:0]      FLUSH_LD  = 3'(FLUSH_CYCLES);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      fcnt_q, fcnt_d;
    logic            if_flush_q, if_flush_d;
    logic            id_flush_q, id_flush_d;
    logic            halted_q, halted_d;
    logic            mis_q, mis_d;
    logic [15:0]     rcnt_q, rcnt_d;

    // Redirect target is word aligned; address bits above the PC width are
    // dropped, and only the low two bits feed the misalignment flag.
    logic [PC_W-1:0] br_target;
    logic            br_misaligned;
    logic            unused_br_hi;

    assign br_target     = {br_pc[PC_W-1:2], 2'b00};
    assign br_misaligned = |br_pc[1:0];
    assign unused_br_hi  = ^br_pc[31:PC_W];

    // Next-state and next-output computation; priority halt_req > pc_sel > stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fcnt_d     = fcnt_q;
        if_flush_d = if_flush_q;
        id_flush_d = id_flush_q;
        halted_d   = halted_q;
        mis_d      = mis_q;
        rcnt_d     = rcnt_q;

        case (state_q)
            S_RUN, S_FLUSH: begin
                if (halt_req) begin
                    // Freeze fetch; IF/ID keeps getting squashed while halted,
                    // any pending flush window is abandoned.
                    state_d    = S_HALT;
                    fcnt_d     = '0;
                    halted_d   = 1'b1;
                    if_flush_d = 1'b1;
                    id_flush_d = 1'b0;
                end else if (pc_sel) begin
                    state_d    = S_FLUSH;
                    pc_d       = br_target;
                    fcnt_d     = FLUSH_LD;
                    if_flush_d = 1'b1;
                    id_flush_d = 1'b1;
                    if (br_misaligned) mis_d = 1'b1;
                    if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
                end else if (state_q == S_FLUSH) begin
                    // Bubbles live in the pipe registers only, so fetch keeps
                    // advancing and stall is not honoured here.
                    pc_d   = pc_q + PC_INC;
                    fcnt_d = fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) begin
                        state_d    = S_RUN;
                        if_flush_d = 1'b0;
                        id_flush_d = 1'b0;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            S_HALT: begin
                if (resume && !halt_req) begin
                    state_d    = S_RUN;
                    halted_d   = 1'b0;
                    if_flush_d = 1'b0;
                    id_flush_d = 1'b0;
                end
            end
            default: begin
                state_d    = S_RUN;
                fcnt_d     = '0;
                if_flush_d = 1'b0;
                id_flush_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            fcnt_q     <= '0;
            if_flush_q <= 1'b0;
            id_flush_q <= 1'b0;
            halted_q   <= 1'b0;
            mis_q      <= 1'b0;
            rcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fcnt_q     <= fcnt_d;
            if_flush_q <= if_flush_d;
            id_flush_q <= id_flush_d;
            halted_q   <= halted_d;
            mis_q      <= mis_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign pc           = pc_q;
    assign if_flush     = if_flush_q;
    assign id_flush     = id_flush_q;
    assign halted       = halted_q;
    assign misalign_err = mis_q;
    assign redirect_cnt = rcnt_q;

endmodule
